// File: rtl/sha1_pkg.sv
// Shared SHA-1 round definitions: round constants, band boundaries, state type and rotate helper.
package sha1_pkg;

  localparam logic [31:0] K_BAND0 = 32'h5A827999;
  localparam logic [31:0] K_BAND1 = 32'h6ED9EBA1;
  localparam logic [31:0] K_BAND2 = 32'h8F1BBCDC;
  localparam logic [31:0] K_BAND3 = 32'hCA62C1D6;

  localparam logic [6:0] BAND0_END = 7'd19;
  localparam logic [6:0] BAND1_END = 7'd39;
  localparam logic [6:0] BAND2_END = 7'd59;
  localparam logic [6:0] BAND3_END = 7'd79;

  typedef enum logic [1:0] {
    BAND_CH   = 2'd0,
    BAND_PAR1 = 2'd1,
    BAND_MAJ  = 2'd2,
    BAND_PAR2 = 2'd3
  } sha1_band_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } sha1_state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  // Rounds above the last band fall into BAND_PAR2; the caller flags them separately.
  function automatic sha1_band_t round_band(input logic [6:0] t);
    sha1_band_t band;
    if (t <= BAND0_END) begin
      band = BAND_CH;
    end else if (t <= BAND1_END) begin
      band = BAND_PAR1;
    end else if (t <= BAND2_END) begin
      band = BAND_MAJ;
    end else begin
      band = BAND_PAR2;
    end
    return band;
  endfunction

endpackage

// File: rtl/sha1_round_f.sv
// SHA-1 round logic function f and additive constant K, selected by round index.
module sha1_round_f
  import sha1_pkg::*;
(
  input  logic [6:0]  round,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] f,
  output logic [31:0] k
);

  sha1_band_t band_s;

  assign band_s = round_band(round);

  // Band-dependent boolean function and constant.
  always_comb begin
    f = 32'd0;
    k = 32'd0;
    case (band_s)
      BAND_CH: begin
        f = (b & c) | (~b & d);
        k = K_BAND0;
      end
      BAND_PAR1: begin
        f = b ^ c ^ d;
        k = K_BAND1;
      end
      BAND_MAJ: begin
        f = (b & c) | (b & d) | (c & d);
        k = K_BAND2;
      end
      BAND_PAR2: begin
        f = b ^ c ^ d;
        k = K_BAND3;
      end
      default: begin
        f = 32'd0;
        k = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/sha1_compression_round.sv
// One SHA-1 compression round. Define SHA1_COMPRESSION_REG_OUT_EN for a registered
// (1-cycle latency) output; the default build is purely combinational.
module sha1_compression_round
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [6:0]   round,
  input  logic [31:0]  w,
  input  logic [159:0] hash_state_in,
  output logic [159:0] hash_state_out,
  output logic         out_valid,
  output logic         round_err
);

  sha1_state_t cur_s;
  sha1_state_t nxt_s;
  logic [31:0] f_s;
  logic [31:0] k_s;
  logic [31:0] t_s;
  logic        round_err_s;

  assign cur_s = hash_state_in;

  sha1_round_f u_round_f (
    .round (round),
    .b     (cur_s.b),
    .c     (cur_s.c),
    .d     (cur_s.d),
    .f     (f_s),
    .k     (k_s)
  );

  // Five-operand modular sum; carries out of bit 31 are dropped by the 32-bit result.
  assign t_s         = rotl32(cur_s.a, 5'd5) + f_s + cur_s.e + k_s + w;
  assign round_err_s = (round > BAND3_END);

  // Out-of-range rounds pass the state through untouched.
  always_comb begin
    nxt_s = cur_s;
    if (round_err_s) begin
      nxt_s = cur_s;
    end else begin
      nxt_s.a = t_s;
      nxt_s.b = cur_s.a;
      nxt_s.c = rotl32(cur_s.b, 5'd30);
      nxt_s.d = cur_s.c;
      nxt_s.e = cur_s.d;
    end
  end

`ifdef SHA1_COMPRESSION_REG_OUT_EN
  // Output register loads every cycle; reset clears any in-flight result at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_state_out <= 160'd0;
      out_valid      <= 1'b0;
      round_err      <= 1'b0;
    end else begin
      hash_state_out <= nxt_s;
      out_valid      <= in_valid;
      round_err      <= round_err_s;
    end
  end
`else
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = clk ^ rst;

  assign hash_state_out = nxt_s;
  assign out_valid      = in_valid;
  assign round_err      = round_err_s;
`endif

endmodule

// File: tb/tb_sha1_compression_round.sv
// Self-checking bench for sha1_compression_round (both build variants).
module tb_sha1_compression_round;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [6:0]   round = 7'd0;
  logic [31:0]  w = 32'd0;
  logic [159:0] hash_state_in = 160'd0;
  logic [159:0] hash_state_out;
  logic         out_valid;
  logic         round_err;

  int n_cmp  = 0;
  int n_fail = 0;

  sha1_compression_round dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .round          (round),
    .w              (w),
    .hash_state_in  (hash_state_in),
    .hash_state_out (hash_state_out),
    .out_valid      (out_valid),
    .round_err      (round_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] st;
    logic [31:0]  wv;
    logic [6:0]   t;
    logic         v;
    logic [159:0] exp_st;
    logic         exp_err;
    string        name;
  } vec_t;

  typedef struct {
    logic [159:0] exp_st;
    logic         exp_err;
    logic         exp_v;
    string        name;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[16];

  localparam logic [159:0] ABC_ST = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
  localparam logic [159:0] ABC_R0 = {32'h0116FC33, 32'h67452301, 32'h7BF36AE2, 32'h98BADCFE, 32'h10325476};
  localparam logic [159:0] ABC_R1 = {32'h8990536D, 32'h0116FC33, 32'h59D148C0, 32'h7BF36AE2, 32'h98BADCFE};

  function automatic logic [159:0] model(input logic [159:0] s, input logic [31:0] wv, input logic [6:0] t);
    logic [31:0] a, b, c, d, e, f, k, tt;
    {a, b, c, d, e} = s;
    if (t >= 7'd80) return s;
    if (t < 7'd20) begin
      f = d ^ (b & (c ^ d));
      k = 32'h5A827999;
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
      k = 32'h6ED9EBA1;
    end else if (t < 7'd60) begin
      f = (b & c) | (d & (b | c));
      k = 32'h8F1BBCDC;
    end else begin
      f = b ^ c ^ d;
      k = 32'hCA62C1D6;
    end
    tt = {a[26:0], a[31:27]} + f + e + k + wv;
    return {tt, a, b[1:0], b[31:2], c, d};
  endfunction

  task automatic cmp(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out();
    sb_t item;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: output with no expected entry");
    end else begin
      item = sb_q.pop_front();
      cmp({item.name, " state"}, hash_state_out, item.exp_st);
      cmp({item.name, " err"}, {159'd0, round_err}, {159'd0, item.exp_err});
      cmp({item.name, " valid"}, {159'd0, out_valid}, {159'd0, item.exp_v});
    end
  endtask

  task automatic apply(input vec_t vv);
    sb_t item;
    @(negedge clk);
    hash_state_in = vv.st;
    w             = vv.wv;
    round         = vv.t;
    in_valid      = vv.v;
    item.exp_st   = vv.exp_st;
    item.exp_err  = vv.exp_err;
    item.exp_v    = vv.v;
    item.name     = vv.name;
    sb_q.push_back(item);
`ifdef SHA1_COMPRESSION_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check_out();
  endtask

  initial begin
    logic [6:0]   edges[7];
    logic [159:0] rs;
    logic [31:0]  rw;

    edges = '{7'd19, 7'd20, 7'd39, 7'd40, 7'd59, 7'd60, 7'd79};

    vecs[0] = '{160'd0, 32'd0, 7'd0,  1'b1, {32'h5A827999, 128'd0}, 1'b0, "zero_t0"};
    vecs[1] = '{160'd0, 32'd0, 7'd20, 1'b0, {32'h6ED9EBA1, 128'd0}, 1'b0, "zero_t20"};
    vecs[2] = '{160'd0, 32'd0, 7'd40, 1'b1, {32'h8F1BBCDC, 128'd0}, 1'b0, "zero_t40"};
    vecs[3] = '{160'd0, 32'd0, 7'd60, 1'b1, {32'hCA62C1D6, 128'd0}, 1'b0, "zero_t60"};
    vecs[4] = '{ABC_ST, 32'h61626380, 7'd0, 1'b1, ABC_R0, 1'b0, "abc_t0"};
    vecs[5] = '{ABC_R0, 32'd0, 7'd1, 1'b0, ABC_R1, 1'b0, "abc_t1"};
    vecs[6] = '{{128'd0, 32'hFFFFFFFF}, 32'd1, 7'd0, 1'b1, {32'h5A827999, 128'd0}, 1'b0, "carry_wrap"};
    vecs[7] = '{ABC_ST, 32'h12345678, 7'd80,  1'b1, ABC_ST, 1'b1, "oor_t80"};
    vecs[8] = '{ABC_R1, 32'h9ABCDEF0, 7'd127, 1'b0, ABC_R1, 1'b1, "oor_t127"};
    rs = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 7; i++) begin
      rw = $urandom;
      vecs[9 + i] = '{rs, rw, edges[i], (i % 2 == 0), model(rs, rw, edges[i]), 1'b0,
                     $sformatf("edge_t%0d", edges[i])};
    end

`ifdef SHA1_COMPRESSION_REG_OUT_EN
    #2;
    cmp("reset state", hash_state_out, 160'd0);
    cmp("reset valid", {159'd0, out_valid}, 160'd0);
    cmp("reset err", {159'd0, round_err}, 160'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    #2;
    cmp("idle valid", {159'd0, out_valid}, 160'd0);
    cmp("idle err", {159'd0, round_err}, 160'd0);
    rst = 1'b0;
`endif

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
    end

`ifdef SHA1_COMPRESSION_REG_OUT_EN
    // Valid pulse: high for one cycle, then low.
    @(negedge clk);
    hash_state_in = ABC_ST; w = 32'h61626380; round = 7'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cmp("pulse valid hi", {159'd0, out_valid}, {159'd0, 1'b1});
    @(negedge clk);
    cmp("pulse valid lo", {159'd0, out_valid}, 160'd0);
    cmp("pulse state", hash_state_out, ABC_R0);

    // Reset asserted between edges clears outputs immediately and holds them.
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    cmp("pre-rst state", hash_state_out, ABC_R0);
    #2;
    rst = 1'b1;
    #1;
    cmp("midrst state", hash_state_out, 160'd0);
    cmp("midrst valid", {159'd0, out_valid}, 160'd0);
    @(posedge clk);
    #1;
    cmp("rst hold state", hash_state_out, 160'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("post-release state", hash_state_out, 160'd0);
    cmp("post-release valid", {159'd0, out_valid}, 160'd0);
    @(posedge clk);
    #1;
    cmp("first load state", hash_state_out, ABC_R0);
    cmp("first load valid", {159'd0, out_valid}, {159'd0, 1'b1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
